// File: rtl/memory_cycle_stage.sv
// M stage of the RV32I pipeline: byte-lane data memory plus the MEM/WB register.
// Optional macro DMEM_MISALIGN_TRAP_EN adds MisalignW and suppresses misaligned accesses.
module memory_cycle_stage #(
    parameter int DMEM_WORDS = 1024,
    parameter int AW         = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ValidM,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic        MemReadM,
    input  logic        ResultSrcM,
    input  logic [2:0]  funct3M,
    input  logic [4:0]  RD_M,
    input  logic [31:0] PCPlus4M,
    input  logic [31:0] ALU_ResultM,
    input  logic [31:0] WriteDataM,
    input  logic        StallW,
    input  logic        FlushW,
    output logic        ValidW,
    output logic        RegWriteW,
    output logic        ResultSrcW,
    output logic [4:0]  RD_W,
    output logic [31:0] PCPlus4W,
    output logic [31:0] ALU_ResultW,
`ifdef DMEM_MISALIGN_TRAP_EN
    output logic        MisalignW,
`endif
    output logic [31:0] ReadDataW
);

    logic [31:0]   mem [DMEM_WORDS];
    logic [AW-1:0] word_idx;
    logic [1:0]    byte_off;
    logic [3:0]    byte_en;
    logic [31:0]   wr_lanes;
    logic          store_commit;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   load_data;
    logic          unused_addr_bits;

    // Address bits above the array are dropped so accesses wrap around the memory.
    assign word_idx         = ALU_ResultM[AW+1:2];
    assign byte_off         = ALU_ResultM[1:0];
    assign unused_addr_bits = ^ALU_ResultM[31:AW+2];

`ifdef DMEM_MISALIGN_TRAP_EN
    logic misaligned;

    always_comb begin
        misaligned = 1'b0;
        if (ValidM && (MemReadM || MemWriteM)) begin
            if ((funct3M == 3'b001 || funct3M == 3'b101) && byte_off[0])
                misaligned = 1'b1;
            else if (funct3M == 3'b010 && byte_off != 2'b00)
                misaligned = 1'b1;
        end
    end

    assign store_commit = rst && ValidM && MemWriteM && !StallW && !misaligned;
`else
    assign store_commit = rst && ValidM && MemWriteM && !StallW;
`endif

    // Halfword and word stores ignore the low offset bits, so misaligned stores land aligned-down.
    always_comb begin
        byte_en  = 4'b0000;
        wr_lanes = WriteDataM;
        case (funct3M)
            3'b000: begin
                byte_en  = 4'b0001 << byte_off;
                wr_lanes = {4{WriteDataM[7:0]}};
            end
            3'b001: begin
                byte_en  = byte_off[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{WriteDataM[15:0]}};
            end
            3'b010:  byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (store_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i])
                    mem[word_idx][i*8 +: 8] <= wr_lanes[i*8 +: 8];
            end
        end
    end

    assign rd_word = mem[word_idx];
    assign rd_byte = rd_word[{byte_off, 3'b000} +: 8];
    assign rd_half = byte_off[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_data = 32'h0;
        if (MemReadM) begin
            case (funct3M)
                3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
                3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
                3'b010:  load_data = rd_word;
                3'b100:  load_data = {24'h0, rd_byte};
                3'b101:  load_data = {16'h0, rd_half};
                default: load_data = 32'h0;
            endcase
        end
    end

    // Flush takes priority over stall; a flushed slot is fully zeroed rather than left stale.
    always_ff @(posedge clk) begin
        if (!rst || FlushW) begin
            ValidW      <= 1'b0;
            RegWriteW   <= 1'b0;
            ResultSrcW  <= 1'b0;
            RD_W        <= 5'd0;
            PCPlus4W    <= 32'h0;
            ALU_ResultW <= 32'h0;
            ReadDataW   <= 32'h0;
`ifdef DMEM_MISALIGN_TRAP_EN
            MisalignW   <= 1'b0;
`endif
        end else if (!StallW) begin
            ValidW      <= ValidM;
`ifdef DMEM_MISALIGN_TRAP_EN
            RegWriteW   <= RegWriteM & ValidM & ~misaligned;
            MisalignW   <= misaligned;
`else
            RegWriteW   <= RegWriteM & ValidM;
`endif
            ResultSrcW  <= ResultSrcM;
            RD_W        <= RD_M;
            PCPlus4W    <= PCPlus4M;
            ALU_ResultW <= ALU_ResultM;
            ReadDataW   <= load_data;
        end
    end

endmodule

// File: doc/memory_cycle_stage.md
Name: memory_cycle_stage

Overview:
- M stage of the 5-stage RV32I pipeline: data memory with byte/halfword/word loads and stores, plus the MEM/WB pipeline register.
- Consumes EX/MEM outputs. Produces the registered W-stage signals that the writeback result mux reads: ResultSrcW, PCPlus4W, ALU_ResultW, ReadDataW.
- Also forwards RegWriteW/RD_W to the register file and the hazard unit.

Parameters:
- DMEM_WORDS, 1024, data memory depth in 32-bit words (power of two).
- AW, 10, word-address width; must equal log2(DMEM_WORDS).

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge
- rst  in  1  synchronous active-low reset, sampled on rising edge of clk
- ValidM  in  1  M-stage instruction valid
- RegWriteM  in  1  instruction writes rd
- MemWriteM  in  1  store instruction
- MemReadM  in  1  load instruction
- ResultSrcM  in  1  0=ALU result, 1=load data
- funct3M  in  3  access size/sign (RV32I LOAD/STORE encoding)
- RD_M  in  5  destination register
- PCPlus4M  in  32  PC+4 of instruction
- ALU_ResultM  in  32  effective address / ALU result
- WriteDataM  in  32  store data (rs2)
- StallW  in  1  hold MEM/WB register, block store commit
- FlushW  in  1  bubble into W stage
- ValidW  out  1  W-stage valid
- RegWriteW  out  1  registered RegWriteM, gated by valid
- ResultSrcW  out  1  registered ResultSrcM
- RD_W  out  5  registered RD_M
- PCPlus4W  out  32  registered PCPlus4M
- ALU_ResultW  out  32  registered ALU_ResultM
- ReadDataW  out  32  registered, extended load data

Behaviour:
- Reset (rst==0 at posedge): every output register cleared to 0. Memory array not reset. A store presented in a reset cycle is not committed.
- Word index = ALU_ResultM[AW+1:2]. Byte offset = ALU_ResultM[1:0]. Upper address bits are ignored, so addresses wrap modulo DMEM_WORDS*4.
- Store commit condition: at posedge when rst==1, ValidM, MemWriteM, and !StallW. Lanes by funct3M:
  - 000 SB: lane = offset, data = WriteDataM[7:0].
  - 001 SH: lanes {offset[1],0} and {offset[1],1}, data = WriteDataM[15:0].
  - 010 SW: all four lanes.
  - Other funct3 values: no write.
- Load path: asynchronous array read of the addressed word, lane-selected and extended, then registered into ReadDataW. Load-to-use latency is 1 cycle (value visible in ReadDataW the cycle after M).
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend half.
  - 010 LW: full word.
  - 100 LBU / 101 LHU: zero-extend.
  - Other funct3 values, or MemReadM==0: ReadDataW gets 0.
- Misalignment (LH/SH with offset[0]=1; LW/SW with offset!=0): access uses the half/word containing the address with the low offset bits forced to 0. No trap in base build.
- Same-cycle load and store to the same word cannot occur (single port, one instruction per stage). A load in the cycle after a store reads the new data.
- MEM/WB register update at posedge when rst==1, in priority order:
  - FlushW=1: ValidW=0, RegWriteW=0. Data fields are don't-care and are cleared to 0. Flush wins over StallW.
  - StallW=1: all W outputs hold.
  - Otherwise: load all fields from M inputs, ValidW=ValidM, RegWriteW=RegWriteM&ValidM.
- Invalid M instruction (ValidM=0): no store commit, RegWriteW=0.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined:
  - Adds output MisalignW (1 bit), registered like the other W fields and cleared on reset/flush.
  - A misaligned valid load or store sets MisalignW=1, suppresses the store commit, and forces RegWriteW=0.
- Undefined:
  - No MisalignW port.
  - Misaligned accesses follow the base-build behaviour above.

Test Plan:
- Reset: hold rst=0 for 2 cycles with MemWriteM=1, ValidM=1, addr 0x10, data 0xDEADBEEF -> all W outputs 0. Later LW 0x10 returns the pre-reset content, not 0xDEADBEEF.
- Sizes: SW 0x20←0x8899AABB, then:
  - SB 0x21←0x7F: LW 0x20 gives 0x88997FBB.
  - LB 0x23: ReadDataW=0xFFFFFF88.
  - LBU 0x23: 0x00000088.
  - LH 0x22: 0xFFFF8899.
  - LHU 0x20: 0x00007FBB.
- Stall/flush: StallW=1 for 3 cycles during SW 0x40←0x1234 -> W outputs frozen and the store commits only on the cycle StallW drops. FlushW=1 together with StallW=1 -> ValidW=0, RegWriteW=0.
- Pass-through: ALU instruction with RegWriteM=1, RD_M=5, ALU_ResultM=0xCAFE, PCPlus4M=0x104 -> next cycle RegWriteW=1, RD_W=5, ALU_ResultW=0xCAFE, PCPlus4W=0x104, ResultSrcW=0.
- Wrap and misalignment: SW to address DMEM_WORDS*4+8 aliases word 2 (read back via LW 0x8). LW 0x0A with trap macro undefined returns word 2. With DMEM_MISALIGN_TRAP_EN defined, SW 0x0A leaves memory unchanged and MisalignW=1.
